// File: rtl/net_resolve_pkg.sv
// Shared types and the per-bit resolution rule for net_resolve_pipe.
package net_resolve_pkg;

    typedef enum logic [1:0] {
        RES_AND  = 2'd0,
        RES_OR   = 2'd1,
        RES_TRI  = 2'd2,
        RES_RSVD = 2'd3
    } res_mode_e;

    typedef struct packed {
        logic val;
        logic xz;
        logic conf;
    } bit_res_t;

    // any0/any1/anyx summarise the non-z enabled drivers of one bit.
    function automatic bit_res_t resolve_bit(input res_mode_e mode, input logic any0,
                                             input logic any1, input logic anyx);
        bit_res_t r;
        r.val  = 1'b0;
        r.xz   = 1'b0;
        r.conf = 1'b0;
        if (mode == RES_RSVD) begin
            r.val  = 1'bx;
            r.xz   = 1'b1;
            r.conf = 1'b1;
        end else if (!any0 && !any1 && !anyx) begin
            r.val = 1'bz;
            r.xz  = 1'b1;
        end else begin
            case (mode)
                RES_AND: begin
                    if (any0)      r.val = 1'b0;
                    else if (anyx) begin r.val = 1'bx; r.xz = 1'b1; end
                    else           r.val = 1'b1;
                end
                RES_OR: begin
                    if (any1)      r.val = 1'b1;
                    else if (anyx) begin r.val = 1'bx; r.xz = 1'b1; end
                    else           r.val = 1'b0;
                end
                default: begin
                    r.conf = any0 && any1;
                    if (anyx || r.conf) begin r.val = 1'bx; r.xz = 1'b1; end
                    else                r.val = any1;
                end
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/net_resolve_ch.sv
// Combinational resolver for one channel: DRV four-state drivers of W bits to one value.
module net_resolve_ch
    import net_resolve_pkg::*;
#(
    parameter int DRV = 2,
    parameter int W   = 30
) (
    input  res_mode_e              i_mode,
    input  logic [DRV-1:0]         i_en,
    input  logic [DRV-1:0][W-1:0]  i_data,
    output logic [W-1:0]           o_data,
    output logic                   o_xz,
    output logic                   o_conflict
);

    always_comb begin
        bit_res_t w_bit;
        logic     w_any0, w_any1, w_anyx;
        o_data     = '0;
        o_xz       = 1'b0;
        o_conflict = 1'b0;
        w_bit      = '0;
        w_any0     = 1'b0;
        w_any1     = 1'b0;
        w_anyx     = 1'b0;
        for (int unsigned b = 0; b < W; b++) begin
            w_any0 = 1'b0;
            w_any1 = 1'b0;
            w_anyx = 1'b0;
            // Disabled and z drivers fall through every test and are ignored.
            for (int unsigned d = 0; d < DRV; d++) begin
                if (i_en[d]) begin
                    if (i_data[d][b] === 1'b0)      w_any0 = 1'b1;
                    else if (i_data[d][b] === 1'b1) w_any1 = 1'b1;
                    else if (i_data[d][b] === 1'bx) w_anyx = 1'b1;
                end
            end
            w_bit      = resolve_bit(i_mode, w_any0, w_any1, w_anyx);
            o_data[b]  = w_bit.val;
            o_xz       = o_xz | w_bit.xz;
            o_conflict = o_conflict | w_bit.conf;
        end
    end

endmodule

// File: rtl/net_resolve_pipe.sv
// Two-stage valid/ready pipeline resolving CH multi-driver nets (AND/OR/TRI per bit).
// Define XZ_STATS_EN to build saturating per-channel X/Z result counters.
module net_resolve_pipe
    import net_resolve_pkg::*;
#(
    parameter int CH    = 3,
    parameter int DRV   = 2,
    parameter int W     = 30,
    parameter int CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    in_mode,
    input  logic [CH*DRV-1:0]             in_en,
    input  logic [CH-1:0][DRV-1:0][W-1:0] in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CH-1:0][W-1:0]          out_data,
    output logic [CH-1:0]                 out_xz,
    output logic [CH-1:0]                 out_conflict,
    input  logic                          stat_clr,
    output logic [CH-1:0][CNT_W-1:0]      stat_xz_cnt
);

    logic                          r_s1_valid;
    res_mode_e                     r_s1_mode;
    logic [CH*DRV-1:0]             r_s1_en;
    logic [CH-1:0][DRV-1:0][W-1:0] r_s1_data;
    logic                          r_s2_valid;
    logic [CH-1:0][W-1:0]          r_out_data;
    logic [CH-1:0]                 r_out_xz, r_out_conf;
    logic [CH-1:0][W-1:0]          w_res_data;
    logic [CH-1:0]                 w_res_xz, w_res_conf;
    logic                          w_s2_load, w_s1_load;

    // S2 frees the same cycle out_ready is seen, so S1 and the input unstall at once.
    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= RES_AND;
            r_s1_en    <= '0;
            r_s1_data  <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_mode <= res_mode_e'(in_mode);
                r_s1_en   <= in_en;
                r_s1_data <= in_data;
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        net_resolve_ch #(.DRV(DRV), .W(W)) u_ch (
            .i_mode     (r_s1_mode),
            .i_en       (r_s1_en[c*DRV +: DRV]),
            .i_data     (r_s1_data[c]),
            .o_data     (w_res_data[c]),
            .o_xz       (w_res_xz[c]),
            .o_conflict (w_res_conf[c])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_out_data <= '0;
            r_out_xz   <= '0;
            r_out_conf <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_res_data;
                r_out_xz   <= w_res_xz;
                r_out_conf <= w_res_conf;
            end
        end
    end

    assign out_valid    = r_s2_valid;
    assign out_data     = r_out_data;
    assign out_xz       = r_out_xz;
    assign out_conflict = r_out_conf;

`ifdef XZ_STATS_EN
    logic [CH-1:0][CNT_W-1:0] r_xz_cnt;

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            r_xz_cnt <= '0;
        end else if (r_s2_valid && out_ready) begin
            for (int unsigned c = 0; c < CH; c++) begin
                if (r_out_xz[c] && (r_xz_cnt[c] != '1)) r_xz_cnt[c] <= r_xz_cnt[c] + 1'b1;
            end
        end
    end

    assign stat_xz_cnt = r_xz_cnt;
`else
    logic w_unused_stat_clr;
    assign w_unused_stat_clr = stat_clr;
    assign stat_xz_cnt       = '0;
`endif

endmodule

// File: tb/tb_net_resolve_pipe.sv
// Bench for net_resolve_pipe: directed vectors against a queue-based reference model.
`timescale 1ns/1ps
module tb_net_resolve_pipe;

    localparam int CH    = 3;
    localparam int DRV   = 2;
    localparam int W     = 4;
    localparam int CNT_W = 2;
    localparam int DW    = CH * DRV * W;
    localparam int unsigned CMAX = (1 << CNT_W) - 1;
`ifdef XZ_STATS_EN
    localparam int unsigned SAT_EXP = CMAX;
`else
    localparam int unsigned SAT_EXP = 0;
`endif

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic                          in_valid = 1'b0;
    logic                          in_ready;
    logic [1:0]                    in_mode = '0;
    logic [CH*DRV-1:0]             in_en = '0;
    logic [CH-1:0][DRV-1:0][W-1:0] in_data = '0;
    logic                          out_valid;
    logic                          out_ready = 1'b1;
    logic [CH-1:0][W-1:0]          out_data;
    logic [CH-1:0]                 out_xz, out_conflict;
    logic                          stat_clr = 1'b0;
    logic [CH-1:0][CNT_W-1:0]      stat_xz_cnt;

    net_resolve_pipe #(.CH(CH), .DRV(DRV), .W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_en(in_en), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_xz(out_xz), .out_conflict(out_conflict),
        .stat_clr(stat_clr), .stat_xz_cnt(stat_xz_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]                    mode;
        logic [CH*DRV-1:0]             en;
        logic [CH-1:0][DRV-1:0][W-1:0] data;
    } txn_t;

    // d: known result bits (0 where unknown), m: bits that must be x or z
    typedef struct {
        logic [CH-1:0][W-1:0] d;
        logic [CH-1:0][W-1:0] m;
        logic [CH-1:0]        xz;
        logic [CH-1:0]        cf;
        int unsigned          acc;
    } exp_t;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input txn_t t);
        exp_t e;
        e.d = '0; e.m = '0; e.xz = '0; e.cf = '0; e.acc = 0;
        for (int c = 0; c < CH; c++) begin
            for (int b = 0; b < W; b++) begin
                int n0, n1, nx;
                n0 = 0; n1 = 0; nx = 0;
                for (int d = 0; d < DRV; d++) begin
                    if (t.en[c*DRV+d]) begin
                        if (t.data[c][d][b] === 1'b0)      n0++;
                        else if (t.data[c][d][b] === 1'b1) n1++;
                        else if (t.data[c][d][b] === 1'bx) nx++;
                    end
                end
                if (t.mode == 2'd3) begin
                    e.m[c][b] = 1'b1;
                    e.cf[c]   = 1'b1;
                end else if (n0 + n1 + nx == 0) begin
                    e.m[c][b] = 1'b1;
                end else if (t.mode == 2'd0) begin
                    if (n0 > 0)      e.d[c][b] = 1'b0;
                    else if (nx > 0) e.m[c][b] = 1'b1;
                    else             e.d[c][b] = 1'b1;
                end else if (t.mode == 2'd1) begin
                    if (n1 > 0)      e.d[c][b] = 1'b1;
                    else if (nx > 0) e.m[c][b] = 1'b1;
                    else             e.d[c][b] = 1'b0;
                end else begin
                    if (n0 > 0 && n1 > 0) e.cf[c] = 1'b1;
                    if (nx > 0 || (n0 > 0 && n1 > 0)) e.m[c][b] = 1'b1;
                    else e.d[c][b] = (n1 > 0);
                end
            end
            e.xz[c] = |e.m[c];
        end
        return e;
    endfunction

    function automatic txn_t mk(input logic [1:0] mode, input logic [CH*DRV-1:0] en,
                                input logic [CH-1:0][DRV-1:0][W-1:0] data);
        txn_t t;
        t.mode = mode; t.en = en; t.data = data;
        return t;
    endfunction

    int unsigned edge_n = 0;
    bit          started = 1'b0;
    bit          rst_q = 1'b0;

    always @(posedge clk) begin
        edge_n++;
        rst_q = rst;
        if (rst) started = 1'b1;
    end

    int unsigned bp_mode = 0;
    int unsigned bp_start = 0;
    logic        manual_ready = 1'b1;

    always @(posedge clk) begin
        #2;
        case (bp_mode)
            0: out_ready = 1'b1;
            1: out_ready = !(edge_n >= bp_start && edge_n < bp_start + 4);
            2: out_ready = ($urandom % 3) != 0;
            default: out_ready = manual_ready;
        endcase
    end

    exp_t        q[$];
    int unsigned last_pop = 0;
    int unsigned cnt_m[CH] = '{default: 0};

    always @(negedge clk) begin
        bit   exp_v, exp_r;
        exp_t f, nt;
        txn_t t;
        if (started) begin
            exp_r = !(q.size() >= 2 && !out_ready);
            exp_v = (q.size() > 0) && (edge_n >= q[0].acc + 1) && (edge_n >= last_pop);
            if (rst_q) begin
                chk("rst_out_data", out_data, 0);
                chk("rst_out_xz", out_xz, 0);
                chk("rst_out_conflict", out_conflict, 0);
            end
            chk("in_ready", in_ready, exp_r);
            chk("out_valid", out_valid, exp_v);
            if (exp_v) begin
                f = q[0];
                for (int c = 0; c < CH; c++) chk("out_data", out_data[c] & ~f.m[c], f.d[c]);
                chk("out_xz", out_xz, f.xz);
                chk("out_conflict", out_conflict, f.cf);
            end
            for (int c = 0; c < CH; c++) chk("stat_xz_cnt", stat_xz_cnt[c], cnt_m[c]);
            if (rst) begin
                q.delete();
                last_pop = 0;
                foreach (cnt_m[c]) cnt_m[c] = 0;
            end else begin
`ifdef XZ_STATS_EN
                if (stat_clr) begin
                    foreach (cnt_m[c]) cnt_m[c] = 0;
                end else if (exp_v && out_ready) begin
                    foreach (cnt_m[c]) if (f.xz[c] && cnt_m[c] < CMAX) cnt_m[c]++;
                end
`endif
                if (exp_v && out_ready) begin
                    void'(q.pop_front());
                    last_pop = edge_n + 1;
                end
                if (in_valid && exp_r) begin
                    t = mk(in_mode, in_en, in_data);
                    nt = model(t);
                    nt.acc = edge_n + 1;
                    q.push_back(nt);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input txn_t t);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1; in_mode = t.mode; in_en = t.en; in_data = t.data;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        chk("accept", ok, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) tick();
        chk("drain", q.size(), 0);
    endtask

    txn_t dir[7];
    txn_t stx;
    exp_t p;

    initial begin
        dir[0] = mk(2'd0, 6'b111111, {4'b0110, 4'b1111, 4'b1010, 4'b1100, 4'b0111, 4'b1x11});
        dir[1] = mk(2'd2, 6'b111111, {4'b1000, 4'b1x00, 4'b1110, 4'b1010, 4'b0011, 4'b0011});
        dir[2] = mk(2'd2, 6'b110111, {4'b1000, 4'b1x00, 4'b1110, 4'b1010, 4'b0011, 4'b0011});
        dir[3] = mk(2'd1, 6'b000000, {4'b1111, 4'b0101, 4'b0011, 4'b1100, 4'b1001, 4'b0110});
        dir[4] = mk(2'd3, 6'b111111, {4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000});
        dir[5] = mk(2'd1, 6'b111111, {4'b0000, 4'b0000, 4'b0101, 4'b1010, 4'b1x00, 4'b0000});
        dir[6] = mk(2'd2, 6'b010101, {4'b1111, 4'b0001, 4'b0000, 4'b0110, 4'b1111, 4'b1001});
        stx    = mk(2'd1, 6'b001111, '0);

        p = model(dir[1]);
        chk("pin_tri_mask", p.m[1], 4'b0100);
        chk("pin_tri_data", p.d[1], 4'b1010);
        chk("pin_tri_conflict", p.cf[1], 1'b1);
        p = model(dir[2]);
        chk("pin_tri_dis_mask", p.m[1], 4'b0000);
        chk("pin_tri_dis_data", p.d[1], 4'b1010);
        chk("pin_tri_dis_conflict", p.cf[1], 1'b0);
        p = model(dir[3]);
        chk("pin_or_alloff_mask", p.m, 12'hfff);
        chk("pin_or_alloff_xz", p.xz, 3'b111);
        p = model(dir[4]);
        chk("pin_rsvd_conflict", p.cf, 3'b111);
        chk("pin_rsvd_xz", p.xz, 3'b111);

        repeat (3) tick();
        rst = 1'b0;
        tick();

        foreach (dir[i]) send(dir[i]);
        drain();

        bp_mode = 1;
        bp_start = edge_n + 1;
        for (int k = 0; k < 8; k++) send(dir[k % 7]);
        drain();

        bp_mode = 3;
        manual_ready = 1'b0;
        send(dir[0]);
        send(dir[1]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        manual_ready = 1'b1;
        send(dir[5]);
        drain();

        bp_mode = 2;
        for (int k = 0; k < 40; k++) begin
            txn_t t;
            int unsigned pos;
            t.mode = 2'($urandom);
            t.en   = 6'($urandom);
            t.data = DW'($urandom);
            if (k % 5 == 0) begin
                pos = $urandom_range(0, DW - 1);
                t.data[pos / (DRV * W)][(pos / W) % DRV][pos % W] = 1'bx;
            end
            send(t);
            if (k % 7 == 3) tick();
        end
        bp_mode = 0;
        drain();

        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        repeat (5) send(stx);
        drain();
        tick();
        chk("stat_saturate", stat_xz_cnt[2], SAT_EXP);

        bp_mode = 3;
        manual_ready = 1'b0;
        send(stx);
        repeat (3) tick();
        manual_ready = 1'b1;
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("stat_clr_priority", stat_xz_cnt[2], 0);
        bp_mode = 0;
        drain();
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
